// File: rtl/rob_ctrl_if.sv
// rob_ctrl_if: bundles the rename, commit and fetch-redirect signals of the
// reorder-buffer occupancy controller.
//   master : environment side (rename / commit / pipeline status), drives
//            alloc_req_v, retire_num, head_exc, head_pc, pipe_idle
//   slave  : rob_ctrl side, drives alloc_ready, alloc_idx, rob_head/tail/count,
//            rob_empty/full, flush, redirect_v, redirect_pc
interface rob_ctrl_if #(
  parameter int ROB_DEPTH  = 32,
  parameter int PTR_W      = $clog2(ROB_DEPTH),
  parameter int DECODE_NUM = 4,
  parameter int RETIRE_NUM = 4,
  parameter int PC         = 64
) ();
  localparam int RET_W = $clog2(RETIRE_NUM + 1);

  logic [DECODE_NUM-1:0]            alloc_req_v;
  logic                             alloc_ready;
  logic [DECODE_NUM-1:0][PTR_W-1:0] alloc_idx;
  logic [RET_W-1:0]                 retire_num;
  logic                             head_exc;
  logic [PC-1:0]                    head_pc;
  logic                             pipe_idle;
  logic [PTR_W-1:0]                 rob_head;
  logic [PTR_W-1:0]                 rob_tail;
  logic [PTR_W:0]                   rob_count;
  logic                             rob_empty;
  logic                             rob_full;
  logic                             flush;
  logic                             redirect_v;
  logic [PC-1:0]                    redirect_pc;

  modport master (
    output alloc_req_v, retire_num, head_exc, head_pc, pipe_idle,
    input  alloc_ready, alloc_idx, rob_head, rob_tail, rob_count,
           rob_empty, rob_full, flush, redirect_v, redirect_pc
  );

  modport slave (
    input  alloc_req_v, retire_num, head_exc, head_pc, pipe_idle,
    output alloc_ready, alloc_idx, rob_head, rob_tail, rob_count,
           rob_empty, rob_full, flush, redirect_v, redirect_pc
  );
endinterface

// File: rtl/rob_ctrl.sv
// rob_ctrl: occupancy and recovery controller for the reorder buffer.
// Hands out ROB indices to rename, tracks head/tail/count as entries are
// allocated and retired, and on an exception at the head runs the
// RUN -> FLUSH -> REDIRECT recovery sequence.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rob_ctrl_if.slave (allocation, retire, head status, occupancy,
//           flush level and fetch redirect pulse)
module rob_ctrl #(
  parameter int ROB_DEPTH  = 32,
  parameter int PTR_W      = $clog2(ROB_DEPTH),
  parameter int DECODE_NUM = 4,
  parameter int RETIRE_NUM = 4,
  parameter int PC         = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  rob_ctrl_if.slave   bus
);

  localparam int CNT_W = PTR_W + 1;
  localparam int RET_W = $clog2(RETIRE_NUM + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Number of set bits in the rename slot mask.
  function automatic logic [CNT_W-1:0] popcount(input logic [DECODE_NUM-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  state_e           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC-1:0]    redirect_pc_q, redirect_pc_d;

  logic [RET_W-1:0] ret_raw_s;
  logic [CNT_W-1:0] ret_ext_s;
  logic [CNT_W-1:0] ret_eff_s;
  logic [CNT_W-1:0] alloc_n_s;
  logic [CNT_W-1:0] alloc_add_s;
  logic [CNT_W-1:0] free_s;
  logic             run_s;
  logic             alloc_ready_s;
  logic             alloc_fire_s;
  logic             exc_take_s;

  assign ret_raw_s = bus.retire_num;

  // Allocation / retire arithmetic from current state and inputs.
  always_comb begin
    run_s     = (state_q == ST_RUN);
    alloc_n_s = popcount(bus.alloc_req_v);
    // count_q never exceeds ROB_DEPTH, so this never underflows.
    free_s    = CNT_W'(ROB_DEPTH) - count_q;
    ret_ext_s = CNT_W'(ret_raw_s);
    // Retiring more than is valid is a commit-stage error; clamp it.
    if (ret_ext_s > count_q) begin
      ret_eff_s = count_q;
    end else begin
      ret_eff_s = ret_ext_s;
    end
    // Space check deliberately ignores a same-cycle retire.
    alloc_ready_s = run_s && (free_s >= alloc_n_s);
    alloc_fire_s  = alloc_ready_s && (alloc_n_s != '0);
    if (alloc_fire_s) begin
      alloc_add_s = alloc_n_s;
    end else begin
      alloc_add_s = '0;
    end
    exc_take_s = run_s && bus.head_exc && (count_q != '0);
  end

  // Next-state logic for the recovery FSM and the pointers.
  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_RUN: begin
        if (exc_take_s) begin
          // Faulting head is not retired; everything younger is dropped.
          state_d       = ST_FLUSH;
          tail_d        = head_q;
          count_d       = '0;
          redirect_pc_d = bus.head_pc;
        end else begin
          state_d = ST_RUN;
          tail_d  = tail_q + alloc_add_s[PTR_W-1:0];
          head_d  = head_q + ret_eff_s[PTR_W-1:0];
          count_d = count_q + alloc_add_s - ret_eff_s;
        end
      end
      ST_FLUSH: begin
        if (bus.pipe_idle) begin
          state_d = ST_REDIRECT;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Slot indices follow the tail; no input dependency.
  always_comb begin
    for (int i = 0; i < DECODE_NUM; i++) begin
      bus.alloc_idx[i] = tail_q + PTR_W'(i);
    end
  end

  assign bus.alloc_ready = alloc_ready_s;
  assign bus.rob_head    = head_q;
  assign bus.rob_tail    = tail_q;
  assign bus.rob_count   = count_q;
  assign bus.rob_empty   = (count_q == '0);
  assign bus.rob_full    = (count_q == CNT_W'(ROB_DEPTH));
  assign bus.flush       = (state_q == ST_FLUSH);
  assign bus.redirect_v  = (state_q == ST_REDIRECT);
  assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed scoreboard bench for rob_ctrl. The driver pushes one
// expected-output record per cycle; a monitor on the falling edge pops and
// compares. Redirect PCs go through a second queue popped on redirect_v.
module tb_rob_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rob_ctrl_if bus ();

  rob_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // -1 in any field means "not checked this cycle".
  typedef struct {
    int h;
    int t;
    int c;
    int r;
    int f;
    int v;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] pc_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Monitor: compare outputs against the scoreboard away from the rising edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] p;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rob_head",    int'(bus.rob_head),    e.h);
      chk("rob_tail",    int'(bus.rob_tail),    e.t);
      chk("rob_count",   int'(bus.rob_count),   e.c);
      chk("alloc_ready", int'(bus.alloc_ready), e.r);
      chk("flush",       int'(bus.flush),       e.f);
      chk("redirect_v",  int'(bus.redirect_v),  e.v);
      if (e.c >= 0) begin
        chk("rob_empty", int'(bus.rob_empty), (e.c == 0) ? 1 : 0);
        chk("rob_full",  int'(bus.rob_full),  (e.c == 32) ? 1 : 0);
      end
      if (e.t >= 0) begin
        for (int i = 0; i < 4; i++) begin
          chk("alloc_idx", int'(bus.alloc_idx[i]), (e.t + i) % 32);
        end
      end
    end
    if (bus.redirect_v === 1'b1) begin
      checks++;
      if (pc_q.size() == 0) begin
        failures++;
        $display("FAIL redirect_unexpected: got redirect_v=1 expected no redirect at %0t", $time);
      end else begin
        p = pc_q.pop_front();
        if (bus.redirect_pc !== p) begin
          failures++;
          $display("FAIL redirect_pc: got %h expected %h", bus.redirect_pc, p);
        end
      end
    end
  end

  // rst_ctl: 0 normal, 1 assert reset mid-cycle, 2 release reset at cycle start.
  task automatic step(input logic [3:0] req, input logic [2:0] ret, input logic exc,
                      input logic [63:0] pc, input logic idle,
                      input int eh, input int et, input int ec, input int er,
                      input int ef, input int ev, input int rst_ctl);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_ctl == 2) rst_n = 1'b1;
    bus.alloc_req_v = req;
    bus.retire_num  = ret;
    bus.head_exc    = exc;
    bus.head_pc     = pc;
    bus.pipe_idle   = idle;
    if (rst_ctl == 1) begin
      #1;
      rst_n = 1'b0;
    end
    e = '{eh, et, ec, er, ef, ev};
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [3:0] req, input logic [2:0] ret,
                     input int eh, input int et, input int ec, input int er);
    step(req, ret, 1'b0, 64'h0, 1'b1, eh, et, ec, er, 0, 0, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish before 50000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n           = 1'b0;
    bus.alloc_req_v = 4'b0000;
    bus.retire_num  = 3'd0;
    bus.head_exc    = 1'b0;
    bus.head_pc     = 64'h0;
    bus.pipe_idle   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    run(4'b0000, 3'd0, 0, 0, 0, 1);
    // Fill: 8 x 4 allocations, count 0 -> 32
    for (int k = 0; k < 8; k++) run(4'b1111, 3'd0, 0, (4 * k) % 32, 4 * k, 1);
    // Full: 1-slot request refused, retire 4 still applied
    run(4'b0001, 3'd4, 0, 0, 32, 0);
    run(4'b0000, 3'd0, 4, 0, 28, 1);
    // Drain to empty, head wraps 28 -> 0
    for (int k = 0; k < 7; k++) run(4'b0000, 3'd4, (4 + 4 * k) % 32, 0, 28 - 4 * k, 1);
    // Build head=5, tail=15, count=10
    run(4'b1111, 3'd0, 0, 0, 0, 1);
    run(4'b1111, 3'd4, 0, 4, 4, 1);
    run(4'b1111, 3'd1, 4, 8, 4, 1);
    run(4'b0111, 3'd0, 5, 12, 7, 1);
    // Exception at head: retire/alloc ignored, pipe_idle low for 3 cycles
    step(4'b1111, 3'd3, 1'b1, 64'h8000_0040, 1'b0, 5, 15, 10, -1, 0, 0, 0);
    pc_q.push_back(64'h8000_0040);
    step(4'b1111, 3'd3, 1'b1, 64'h8000_0040, 1'b0, 5, 5, 0, 0, 1, 0, 0);
    step(4'b1111, 3'd3, 1'b1, 64'h8000_0040, 1'b0, 5, 5, 0, 0, 1, 0, 0);
    step(4'b1111, 3'd3, 1'b0, 64'h0, 1'b1, 5, 5, 0, 0, 1, 0, 0);
    step(4'b1111, 3'd3, 1'b0, 64'h0, 1'b1, 5, 5, 0, 0, 0, 1, 0);
    // Back in RUN: allocation accepted again
    run(4'b1111, 3'd0, 5, 5, 0, 1);
    // Retire 2, then clamp: count 2 with retire 4
    run(4'b0000, 3'd2, 5, 9, 4, 1);
    run(4'b0000, 3'd4, 7, 9, 2, 1);
    // Walk to head=28, tail=30, count=2 with simultaneous alloc/retire
    run(4'b1111, 3'd0, 9, 9, 0, 1);
    for (int k = 0; k < 4; k++) run(4'b1111, 3'd4, 9 + 4 * k, 13 + 4 * k, 4, 1);
    run(4'b0001, 3'd3, 25, 29, 4, 1);
    // Wrap-around: alloc 4 at tail 30 (idx 30,31,0,1), retire 2
    run(4'b1111, 3'd2, 28, 30, 2, 1);
    // Exception again, then async reset in the middle of FLUSH
    step(4'b0000, 3'd0, 1'b1, 64'h0000_1234, 1'b0, 30, 2, 4, 1, 0, 0, 0);
    step(4'b0000, 3'd0, 1'b0, 64'h0, 1'b0, 30, 30, 0, 0, 1, 0, 0);
    step(4'b0000, 3'd0, 1'b0, 64'h0, 1'b0, 0, 0, 0, 1, 0, 0, 1);
    // Release and resume allocation
    step(4'b1111, 3'd0, 1'b0, 64'h0, 1'b1, 0, 0, 0, 1, 0, 0, 2);
    run(4'b0000, 3'd0, 0, 4, 4, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (pc_q.size() != 0) begin
      failures++;
      $display("FAIL redirect_missing: got %0d pending redirects expected 0", pc_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

Occupancy and recovery controller for the 32-entry reorder buffer. It hands out ROB indices to the rename stage and tracks the head, tail and count as instructions are allocated and retired. On an exception at the ROB head it runs the flush/redirect sequence. It sits between rename (allocation), the commit/retire stage (retire count, head status) and fetch (PC redirect).

## Interface
Parameters:
- ROB_DEPTH, 32, number of ROB entries (power of two)
- PTR_W, 5, log2(ROB_DEPTH)
- DECODE_NUM, 4, rename slots per cycle
- RETIRE_NUM, 4, maximum retires per cycle
- PC, 64, PC width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_req_v  in  DECODE_NUM  rename slot valid, contiguous from bit 0
- alloc_ready  out  1  allocation accepted this cycle if any alloc_req_v set
- alloc_idx  out  DECODE_NUM x PTR_W  ROB index for slot i = tail + i (mod ROB_DEPTH)
- retire_num  in  3  entries retired this cycle by commit stage (0..RETIRE_NUM)
- head_exc  in  1  head entry is complete and carries an exception
- head_pc  in  PC  PC of head entry
- pipe_idle  in  1  issue/execute/write-back hold no in-flight ops
- rob_head  out  PTR_W  oldest entry index
- rob_tail  out  PTR_W  next free index
- rob_count  out  PTR_W+1  valid entries (0..ROB_DEPTH)
- rob_empty  out  1  rob_count == 0
- rob_full  out  1  rob_count == ROB_DEPTH
- flush  out  1  squash all in-flight state (level, high while in FLUSH)
- redirect_v  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  PC  exception PC latched at flush entry

## Operation
- State machine: RUN, FLUSH, REDIRECT.
- In RUN:
  - alloc_n = popcount(alloc_req_v).
  - alloc_ready = (ROB_DEPTH − rob_count) >= alloc_n.
  - alloc_fire = alloc_ready & (alloc_n != 0).
  - ret_eff = min(retire_num, rob_count); excess retire_num is a protocol error and is clamped.
- Update in RUN without exception:
  - tail += alloc_fire ? alloc_n : 0
  - head += ret_eff
  - count += (alloc_fire ? alloc_n : 0) − ret_eff
- Pointers wrap modulo ROB_DEPTH through natural PTR_W truncation.
- alloc_ready uses the current rob_count only. A same-cycle retire does not free space for a same-cycle allocation.
- Exception, RUN → FLUSH:
  - Condition: head_exc & !rob_empty in RUN.
  - retire_num and alloc_req_v are ignored that cycle (the faulting entry is not retired).
  - redirect_pc <= head_pc.
  - tail <= head, count <= 0.
- FLUSH:
  - flush = 1, alloc_ready = 0, retire_num ignored, head_exc ignored.
  - Stays in FLUSH while pipe_idle = 0.
  - FLUSH → REDIRECT on the first cycle pipe_idle = 1, with a minimum of 1 cycle in FLUSH.
- REDIRECT:
  - redirect_v = 1, flush = 0, alloc_ready = 0 for exactly one cycle.
  - REDIRECT → RUN unconditionally.
- Reset (asynchronous assert, any state):
  - State RUN; head = tail = 0; count = 0; redirect_pc = 0.
  - Outputs: alloc_ready = 1, rob_empty = 1, rob_full = 0, flush = 0, redirect_v = 0, alloc_idx = {3,2,1,0}.

## Timing
- alloc_ready, alloc_idx, rob_empty, rob_full, flush and redirect_v are combinational from registered state and current inputs. alloc_idx has no input dependency.
- Allocation and retire effects appear on rob_tail, rob_head and rob_count at the next rising edge (1-cycle latency).
- Exception detect to flush high: 1 cycle. Detect to redirect_v: at least 2 cycles.
  - With pipe_idle already high: flush is high in cycle N+1 and redirect_v in cycle N+2. Allocation is accepted again in cycle N+3.
- Wrap-around: tail = 30 with alloc_n = 4 gives alloc_idx = {1,0,31,30} and next tail = 2.
- Full: rob_count = 32 forces alloc_ready = 0 for any nonzero request. A zero-slot request is a no-op regardless of occupancy.
- Simultaneous alloc and retire on the same edge: both are applied, and the count changes by the net amount.

## Test plan
- Reset then 8 cycles of alloc_req_v = 4'b1111, retire_num = 0:
  - count goes 0→32.
  - alloc_idx in the first cycle is {3,2,1,0}.
  - After cycle 8: rob_full = 1, alloc_ready = 0.
- Full ROB with alloc_req_v = 4'b0001 and retire_num = 4:
  - alloc_ready = 0 in that cycle.
  - Next cycle: count = 28, head = 4, alloc_ready = 1.
- Wrap-around: head = 28, tail = 30, count = 2; alloc 4, retire 2.
  - Next cycle: tail = 2, head = 30, count = 4.
- Exception with count = 10, head = 5, head_pc = 0x8000_0040, retire_num = 3, pipe_idle held 0 for 3 cycles:
  - retire is ignored.
  - Next cycle: count = 0, tail = 5, flush = 1.
  - flush stays high for 3 cycles.
  - Then redirect_v = 1 with redirect_pc = 0x8000_0040.
  - alloc_ready = 0 until the cycle after redirect_v.
- Clamp: count = 2 with retire_num = 4 gives count = 0 and head += 2.
- rst_n asserted mid-FLUSH, asynchronously between edges:
  - Immediately: flush = 0, count = 0, head = tail = 0, alloc_ready = 1.
  - After release: normal allocation resumes.
